xbus_arb: RTL and testbench
===========================

Name: xbus_arb

Overview:
- Two-master arbiter for the single-ported data bus that feeds the address decoder (RAM, register file, LEDs, external port).
- Master 0 is the processor controller. Master 1 is a secondary bus master, e.g. a display refresh or DMA engine.
- Serialises accesses, applies round-robin on ties, and bounds ownership with a burst limit so neither master starves.
- Slave side connects in place of the controller's data-bus outputs.

Parameters:
DATA_W, 32, data bus width
ADDR_W, 12, data address width
MAX_BURST, 4, accesses an owner may make before it must yield to a waiting master (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
m0_req  in  1  master 0 access request; held high while more accesses are pending
m0_we  in  1  master 0 write enable
m0_addr  in  ADDR_W  master 0 address
m0_wdata  in  DATA_W  master 0 write data
m0_gnt  out  1  master 0 owns the bus (registered)
m0_ack  out  1  master 0 access completed, one cycle after issue
m0_rdata  out  DATA_W  master 0 read data, valid while m0_ack=1
m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_ack, m1_rdata  same as the m0_* ports, for master 1
s_sel  out  1  slave-side select to the address decoder
s_we  out  1  slave-side write enable
s_addr  out  ADDR_W  slave-side address
s_wdata  out  DATA_W  slave-side write data
s_rdata  in  DATA_W  slave read data, valid one cycle after s_sel

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values:
  - state=IDLE, all gnt/ack=0, s_sel=0, s_we=0.
  - burst_cnt=0, last_owner=1, so master 0 wins the first tie.
  - s_addr, s_wdata, rdata outputs = 0.
- State IDLE: no grants.
  - Only one req high: that master is chosen.
  - Both high: the master != last_owner is chosen.
  - Next cycle: state=OWN, owner=choice, gnt of owner=1, burst_cnt=0. Grant latency from req is 1 cycle.
- State OWN:
  - s_sel = owner req; s_we/s_addr/s_wdata are muxed combinationally from the owner's inputs.
  - Each cycle with owner req=1 is one issued access.
  - ack of the owner is registered high exactly 1 cycle after each issued access, including the final access before the grant drops.
  - mX_rdata = s_rdata, passed through during the ack cycle; 0 otherwise.
  - burst_cnt increments per issued access and saturates at MAX_BURST.
- Leaving OWN:
  - Owner req=0: next state IDLE, last_owner=owner, gnt=0.
  - Other req=1 and burst_cnt reaches MAX_BURST on this cycle's access: next state IDLE, last_owner=owner. The following IDLE cycle grants the other master.
  - Burst limit reached with other req=0: owner keeps the bus; counter stays saturated.
- Turnaround: each handover has at least one IDLE cycle with both gnt=0. A pending ack is still delivered in that cycle.
- Non-owner: its req is ignored; its gnt and ack stay 0.
- Simultaneous events:
  - Owner drops req in the same cycle the other raises it: IDLE next, then the other master is granted.
  - rst dominates all events. A mid-burst reset aborts with no ack for the in-flight access; its write has already been issued to the slave.
- Masters must hold we/addr/wdata stable while req=1 and gnt=0.

Optional Feature:
- Macro: XBUS_ARB_FIXED_PRIO_EN.
- Defined:
  - Ties in IDLE always go to master 0; last_owner is unused.
  - Master 0 is never forced to yield by the burst limit.
  - The limit still forces master 1 to yield to a waiting master 0 after MAX_BURST accesses.
- Undefined: round-robin and symmetric burst limit as described in Behaviour.

Test Plan:
1. Reset, then m0_req=1 with addr=0x010, we=0, s_rdata=0xA5 -> m0_gnt=1 one cycle after req; s_sel=1 with s_addr=0x010; m0_ack=1 with m0_rdata=0xA5 on the next cycle.
2. m0_req and m1_req rise in the same cycle after reset -> m0 granted first. After m0 releases: one IDLE cycle, then m1_gnt=1. Repeat the tie -> m1 wins, per last_owner.
3. MAX_BURST=4: m0 requests continuously, m1_req=1 from cycle 0 -> exactly 4 m0 accesses and 4 m0_acks, one cycle with both gnt=0, then m1_gnt=1.
4. m0 requests continuously for 10 accesses, m1 idle -> m0_gnt stays 1 throughout; 10 acks; burst_cnt saturated at 4.
5. Assert rst during an m1 write burst on the 2nd access -> next cycle all outputs at reset values; no m1_ack; first tie afterwards goes to m0.
6. With XBUS_ARB_FIXED_PRIO_EN: both masters request continuously -> m0 keeps the grant indefinitely. Drop m0_req -> m1 granted after one IDLE cycle. Raise m0_req -> m1 yields after 4 accesses.

Source files
------------

// File: rtl/xbus_arb.sv
// xbus_arb: two-master arbiter for the single-ported data bus in front of the
// address decoder. Round-robin on ties, burst limit bounds ownership, one idle
// turnaround cycle between owners.
// Optional build macro XBUS_ARB_FIXED_PRIO_EN: master 0 wins every tie and is
// never forced off the bus by the burst limit; master 1 still yields to a
// waiting master 0 after MAX_BURST accesses.
module xbus_arb #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              s_sel,
  output logic              s_we,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic [DATA_W-1:0] s_rdata
);

  localparam int unsigned CNT_W = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t           state;
  logic             owner;
  logic             last_owner;
  logic [CNT_W-1:0] burst_cnt;

  logic             own_req;
  logic             oth_req;
  logic             issue;
  logic [CNT_W-1:0] cnt_next;
  logic             limit_hit;
  logic             may_force;
  logic             yield;
  logic             any_req;
  logic             pick;

  // Owner/other request view, burst accounting and idle-cycle choice
  always_comb begin
    own_req   = owner ? m1_req : m0_req;
    oth_req   = owner ? m0_req : m1_req;
    issue     = (state == OWN) && own_req;
    cnt_next  = (burst_cnt == CNT_W'(MAX_BURST)) ? burst_cnt : burst_cnt + CNT_W'(1);
    limit_hit = (cnt_next == CNT_W'(MAX_BURST));
`ifdef XBUS_ARB_FIXED_PRIO_EN
    may_force = owner;
`else
    may_force = 1'b1;
`endif
    yield     = own_req && oth_req && limit_hit && may_force;
    any_req   = m0_req || m1_req;
    if (m0_req && m1_req) begin
`ifdef XBUS_ARB_FIXED_PRIO_EN
      pick = 1'b0;
`else
      pick = ~last_owner;
`endif
    end else begin
      pick = m1_req;
    end
  end

  // Slave-side mux from the current owner; quiet (zero) when nobody owns the bus
  always_comb begin
    s_sel   = issue;
    s_we    = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    if (state == OWN) begin
      s_we    = owner ? m1_we    : m0_we;
      s_addr  = owner ? m1_addr  : m0_addr;
      s_wdata = owner ? m1_wdata : m0_wdata;
    end
  end

  // Read data is only presented to a master during its ack cycle
  always_comb begin
    m0_rdata = m0_ack ? s_rdata : '0;
    m1_rdata = m1_ack ? s_rdata : '0;
  end

  // Arbitration FSM with registered grants and acks
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      burst_cnt  <= '0;
      m0_gnt     <= 1'b0;
      m1_gnt     <= 1'b0;
      m0_ack     <= 1'b0;
      m1_ack     <= 1'b0;
    end else begin
      m0_ack <= issue && !owner;
      m1_ack <= issue && owner;
      case (state)
        IDLE: begin
          if (any_req) begin
            state     <= OWN;
            owner     <= pick;
            burst_cnt <= '0;
            m0_gnt    <= !pick;
            m1_gnt    <= pick;
          end
        end
        OWN: begin
          if (own_req) begin
            burst_cnt <= cnt_next;
          end
          if (!own_req || yield) begin
            state      <= IDLE;
            last_owner <= owner;
            m0_gnt     <= 1'b0;
            m1_gnt     <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          m0_gnt <= 1'b0;
          m1_gnt <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xbus_arb.sv
// tb_xbus_arb: directed checks of xbus_arb with hand-computed expectations.
module tb_xbus_arb;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              m0_req, m0_we, m1_req, m1_we;
  logic [ADDR_W-1:0] m0_addr, m1_addr, s_addr;
  logic [DATA_W-1:0] m0_wdata, m1_wdata, s_wdata, s_rdata;
  logic              m0_gnt, m0_ack, m1_gnt, m1_ack, s_sel, s_we;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;

  int pass_cnt = 0;
  int total_cnt = 0;
  int ack_cnt;

  always #5 clk = ~clk;

  xbus_arb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .s_sel(s_sel), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one cycle; inputs are changed and outputs sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    tick();
    rst = 1'b0;
    settle();
  endtask

  initial begin
    rst = 1'b1;
    s_rdata = '0;
    do_reset();
    tick();
    do_reset();
    // Reset state
    chk("rst_m0_gnt", 64'(m0_gnt), 64'd0);
    chk("rst_m1_gnt", 64'(m1_gnt), 64'd0);
    chk("rst_acks", 64'({m0_ack, m1_ack}), 64'd0);
    chk("rst_s_sel", 64'(s_sel), 64'd0);
    chk("rst_s_we", 64'(s_we), 64'd0);
    chk("rst_s_addr", 64'(s_addr), 64'd0);
    chk("rst_rdata", 64'({m0_rdata, m1_rdata}), 64'd0);

    // 1: single m0 read
    m0_req = 1'b1; m0_addr = 12'h010; m0_we = 1'b0; s_rdata = 32'hA5;
    settle();
    chk("t1_no_gnt_yet", 64'(m0_gnt), 64'd0);
    tick();
    chk("t1_gnt", 64'(m0_gnt), 64'd1);
    chk("t1_s_sel", 64'(s_sel), 64'd1);
    chk("t1_s_addr", 64'(s_addr), 64'h010);
    chk("t1_no_ack_yet", 64'(m0_ack), 64'd0);
    tick();
    m0_req = 1'b0;
    settle();
    chk("t1_ack", 64'(m0_ack), 64'd1);
    chk("t1_rdata", 64'(m0_rdata), 64'hA5);
    chk("t1_s_sel_off", 64'(s_sel), 64'd0);
    tick();
    chk("t1_release", 64'({m0_gnt, m0_ack}), 64'd0);
    chk("t1_rdata_zero", 64'(m0_rdata), 64'd0);

    // 2: ties and round-robin
    do_reset();
    m0_req = 1'b1; m1_req = 1'b1;
    tick();
    chk("t2_tie1_m0", 64'({m0_gnt, m1_gnt}), 64'b10);
    tick();
    m0_req = 1'b0;
    settle();
    chk("t2_m0_ack", 64'(m0_ack), 64'd1);
    chk("t2_m1_ignored", 64'({m1_gnt, m1_ack}), 64'd0);
    tick();
    m0_req = 1'b1;
    settle();
    chk("t2_idle_turn", 64'({m0_gnt, m1_gnt}), 64'd0);
    tick();
    chk("t2_tie2_m1", 64'({m0_gnt, m1_gnt}), 64'b01);
    tick();
    m1_req = 1'b0;
    settle();
    chk("t2_m1_ack", 64'({m0_ack, m1_ack}), 64'b01);
    tick();
    chk("t2_idle2", 64'({m0_gnt, m1_gnt}), 64'd0);
    tick();
    chk("t2_m0_back", 64'({m0_gnt, m1_gnt}), 64'b10);
    m0_req = 1'b0;

    // 3: burst limit forces handover
    do_reset();
    m0_req = 1'b1; m1_req = 1'b1;
    ack_cnt = 0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("t3_m0_owns", 64'({m0_gnt, m1_gnt}), 64'b10);
      if (m0_ack) ack_cnt++;
    end
    tick();
    chk("t3_turnaround", 64'({m0_gnt, m1_gnt}), 64'd0);
    if (m0_ack) ack_cnt++;
    tick();
    chk("t3_m1_gnt", 64'({m0_gnt, m1_gnt}), 64'b01);
    if (m0_ack) ack_cnt++;
    chk("t3_m0_acks", 64'(ack_cnt), 64'd4);
    m0_req = 1'b0; m1_req = 1'b0;

    // 4: lone owner keeps the bus past the limit
    do_reset();
    m0_req = 1'b1;
    ack_cnt = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("t4_m0_keeps", 64'(m0_gnt), 64'd1);
      if (m0_ack) ack_cnt++;
    end
    tick();
    m0_req = 1'b0;
    settle();
    chk("t4_gnt_last", 64'(m0_gnt), 64'd1);
    if (m0_ack) ack_cnt++;
    chk("t4_acks", 64'(ack_cnt), 64'd10);
    chk("t4_cnt_sat", 64'(dut.burst_cnt), 64'd4);
    tick();
    chk("t4_release", 64'(m0_gnt), 64'd0);

    // 5: reset in the middle of an m1 write burst
    do_reset();
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 12'h3F0; m1_wdata = 32'hDEAD_BEEF;
    tick();
    chk("t5_m1_gnt", 64'(m1_gnt), 64'd1);
    chk("t5_s_we", 64'(s_we), 64'd1);
    chk("t5_s_addr", 64'(s_addr), 64'h3F0);
    chk("t5_s_wdata", 64'(s_wdata), 64'hDEAD_BEEF);
    tick();
    rst = 1'b1;
    settle();
    chk("t5_2nd_issued", 64'({s_sel, m1_ack}), 64'b11);
    tick();
    rst = 1'b0;
    m0_req = 1'b1;
    settle();
    chk("t5_no_ack", 64'({m0_ack, m1_ack}), 64'd0);
    chk("t5_gnt_clr", 64'({m0_gnt, m1_gnt}), 64'd0);
    chk("t5_slave_clr", 64'({s_sel, s_we}), 64'd0);
    chk("t5_addr_clr", 64'(s_addr), 64'd0);
    tick();
    chk("t5_tie_m0", 64'({m0_gnt, m1_gnt}), 64'b10);
    m0_req = 1'b0; m1_req = 1'b0; m1_we = 1'b0;

`ifdef XBUS_ARB_FIXED_PRIO_EN
    // 6: fixed priority
    do_reset();
    m0_req = 1'b1; m1_req = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("t6_m0_holds", 64'({m0_gnt, m1_gnt}), 64'b10);
    end
    tick();
    m0_req = 1'b0;
    settle();
    tick();
    chk("t6_idle", 64'({m0_gnt, m1_gnt}), 64'd0);
    tick();
    chk("t6_m1_gnt", 64'({m0_gnt, m1_gnt}), 64'b01);
    m0_req = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("t6_m1_burst", 64'(m1_gnt), 64'd1);
    end
    tick();
    chk("t6_m1_yield", 64'({m0_gnt, m1_gnt}), 64'd0);
    tick();
    chk("t6_m0_regain", 64'({m0_gnt, m1_gnt}), 64'b10);
    m0_req = 1'b0; m1_req = 1'b0;
`endif

    tick();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
